// File: rtl/dma_host_sequencer.sv
// Host-side sequencer for the DMA controller: issues inicio, loads the three
// counters, fires load, then supervises INT/ACK with timeouts.
module dma_host_sequencer #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_src,
    input  logic [ADDR_W-1:0] req_dst,
    input  logic [CNT_W-1:0]  req_len,
    output logic              inicio,
    output logic [ADDR_W-1:0] cfg_data,
    output logic [2:0]        cfg_wr,
    output logic              load,
    input  logic              int_i,
    input  logic              ack_i,
    output logic              busy,
    output logic              done_pulse,
    output logic              err_timeout
);

    localparam int unsigned TMR_W = CNT_W + 3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_CFG_SRC,
        S_CFG_DST,
        S_CFG_LEN,
        S_WAIT_INT,
        S_GO,
        S_WAIT_ACK,
        S_FIN,
        S_ERR
    } state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  src_q, dst_q;
    logic [CNT_W-1:0]   len_q;
    logic [TMR_W-1:0]   timer_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            timer_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        src_q <= req_src;
                        dst_q <= req_dst;
                        len_q <= req_len;
                    end
                end
                S_CFG_LEN: timer_q <= TMR_W'(TIMEOUT);
                S_WAIT_INT: begin
                    if (!int_i && timer_q != '0)
                        timer_q <= timer_q - TMR_W'(1);
                end
                // DMA needs 4 cycles per byte on top of the base budget
                S_GO: timer_q <= ({3'b000, len_q} << 2) + TMR_W'(TIMEOUT);
                S_WAIT_ACK: begin
                    if (!ack_i && timer_q != '0)
                        timer_q <= timer_q - TMR_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        busy        = 1'b1;
        inicio      = 1'b0;
        load        = 1'b0;
        done_pulse  = 1'b0;
        err_timeout = 1'b0;
        cfg_wr      = '0;
        cfg_data    = '0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid)
                    state_nxt = (req_len == '0) ? S_FIN : S_START;
            end
            S_START: begin
                inicio    = 1'b1;
                state_nxt = S_CFG_SRC;
            end
            S_CFG_SRC: begin
                cfg_wr    = 3'b001;
                cfg_data  = src_q;
                state_nxt = S_CFG_DST;
            end
            S_CFG_DST: begin
                cfg_wr    = 3'b010;
                cfg_data  = dst_q;
                state_nxt = S_CFG_LEN;
            end
            S_CFG_LEN: begin
                cfg_wr    = 3'b100;
                cfg_data  = ADDR_W'(len_q);
                state_nxt = S_WAIT_INT;
            end
            // success is checked first so a response on the expiry cycle wins
            S_WAIT_INT: begin
                if (int_i)
                    state_nxt = S_GO;
                else if (timer_q == '0)
                    state_nxt = S_ERR;
            end
            S_GO: begin
                load      = 1'b1;
                state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (ack_i)
                    state_nxt = S_FIN;
                else if (timer_q == '0)
                    state_nxt = S_ERR;
            end
            S_FIN: begin
                done_pulse = 1'b1;
                state_nxt  = S_IDLE;
            end
            S_ERR: begin
                err_timeout = 1'b1;
                state_nxt   = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dma_host_sequencer.sv
// Directed bench for dma_host_sequencer with TIMEOUT=4: checks every output,
// cycle by cycle, against hand-derived vectors.
module tb_dma_host_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_src, req_dst, req_len;
    logic       inicio;
    logic [7:0] cfg_data;
    logic [2:0] cfg_wr;
    logic       load;
    logic       int_i, ack_i;
    logic       busy, done_pulse, err_timeout;

    int tests = 0;
    int fails = 0;

    // {req_ready, busy, inicio, load, done_pulse, err_timeout, cfg_wr, cfg_data}
    logic [16:0] obs;
    assign obs = {req_ready, busy, inicio, load, done_pulse, err_timeout, cfg_wr, cfg_data};

    localparam logic [16:0] V_IDLE  = {6'b100000, 11'h000};
    localparam logic [16:0] V_START = {6'b011000, 11'h000};
    localparam logic [16:0] V_WAIT  = {6'b010000, 11'h000};
    localparam logic [16:0] V_GO    = {6'b010100, 11'h000};
    localparam logic [16:0] V_FIN   = {6'b010010, 11'h000};
    localparam logic [16:0] V_ERR   = {6'b010001, 11'h000};

    function automatic logic [16:0] v_cfg(input logic [2:0] wr, input logic [7:0] d);
        return {6'b010000, wr, d};
    endfunction

    dma_host_sequencer #(
        .ADDR_W (8),
        .CNT_W  (8),
        .TIMEOUT(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_src    (req_src),
        .req_dst    (req_dst),
        .req_len    (req_len),
        .inicio     (inicio),
        .cfg_data   (cfg_data),
        .cfg_wr     (cfg_wr),
        .load       (load),
        .int_i      (int_i),
        .ack_i      (ack_i),
        .busy       (busy),
        .done_pulse (done_pulse),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // From IDLE: issue request, walk START/CFG_*, return on the first WAIT_INT cycle.
    // With hold=1 req_valid stays high and req_* switch to the next request's values.
    task automatic start_xfer(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                              input logic hold, input logic [7:0] ns, input logic [7:0] nd,
                              input logic [7:0] nl);
        tests++;
        if (obs !== V_IDLE) begin fails++; $display("FAIL xfer_idle obs=%h exp=%h", obs, V_IDLE); end
        req_valid = 1'b1; req_src = s; req_dst = d; req_len = l;
        tick;
        tests++;
        if (obs !== V_START) begin fails++; $display("FAIL xfer_start obs=%h exp=%h", obs, V_START); end
        if (hold) begin
            req_src = ns; req_dst = nd; req_len = nl;
        end else begin
            req_valid = 1'b0; req_src = 8'hEE; req_dst = 8'hEE; req_len = 8'hEE;
        end
        tick;
        tests++;
        if (obs !== v_cfg(3'b001, s)) begin fails++; $display("FAIL xfer_cfg_src obs=%h exp=%h", obs, v_cfg(3'b001, s)); end
        tick;
        tests++;
        if (obs !== v_cfg(3'b010, d)) begin fails++; $display("FAIL xfer_cfg_dst obs=%h exp=%h", obs, v_cfg(3'b010, d)); end
        tick;
        tests++;
        if (obs !== v_cfg(3'b100, l)) begin fails++; $display("FAIL xfer_cfg_len obs=%h exp=%h", obs, v_cfg(3'b100, l)); end
        tick;
        tests++;
        if (obs !== V_WAIT) begin fails++; $display("FAIL xfer_wait_int0 obs=%h exp=%h", obs, V_WAIT); end
    endtask

    // From first WAIT_INT cycle: int_i after n_int more cycles, ack_i n_ack cycles after load.
    task automatic finish_xfer(input int n_int, input int n_ack);
        for (int i = 0; i < n_int; i++) begin
            tick;
            tests++;
            if (obs !== V_WAIT) begin fails++; $display("FAIL fin_wait_int[%0d] obs=%h exp=%h", i, obs, V_WAIT); end
        end
        int_i = 1'b1;
        tick;
        tests++;
        if (obs !== V_GO) begin fails++; $display("FAIL fin_go obs=%h exp=%h", obs, V_GO); end
        for (int i = 0; i < n_ack; i++) begin
            tick;
            tests++;
            if (obs !== V_WAIT) begin fails++; $display("FAIL fin_wait_ack[%0d] obs=%h exp=%h", i, obs, V_WAIT); end
        end
        ack_i = 1'b1;
        int_i = 1'b0;
        tick;
        tests++;
        if (obs !== V_FIN) begin fails++; $display("FAIL fin_done obs=%h exp=%h", obs, V_FIN); end
        ack_i = 1'b0;
        tick;
        tests++;
        if (obs !== V_IDLE) begin fails++; $display("FAIL fin_idle obs=%h exp=%h", obs, V_IDLE); end
    endtask

    task automatic test_reset;
        rst = 1'b0; req_valid = 1'b0; req_src = '0; req_dst = '0; req_len = '0;
        int_i = 1'b0; ack_i = 1'b0;
        tick;
        tick;
        tests++;
        if (obs !== V_IDLE) begin fails++; $display("FAIL reset_values obs=%h exp=%h", obs, V_IDLE); end
        rst = 1'b1;
        tick;
    endtask

    task automatic test_basic;
        start_xfer(8'h10, 8'h80, 8'h03, 1'b0, 8'h00, 8'h00, 8'h00);
        finish_xfer(1, 12);
    endtask

    task automatic test_zero_len;
        req_valid = 1'b1; req_src = 8'h33; req_dst = 8'h44; req_len = 8'h00;
        tick;
        tests++;
        if (obs !== V_FIN) begin fails++; $display("FAIL zero_len_done obs=%h exp=%h", obs, V_FIN); end
        req_valid = 1'b0;
        tick;
        tests++;
        if (obs !== V_IDLE) begin fails++; $display("FAIL zero_len_idle obs=%h exp=%h", obs, V_IDLE); end
    endtask

    task automatic test_int_timeout;
        start_xfer(8'h01, 8'h02, 8'h01, 1'b0, 8'h00, 8'h00, 8'h00);
        ack_i = 1'b1;   // early ACK during WAIT_INT must be ignored
        for (int i = 0; i < 4; i++) begin
            tick;
            tests++;
            if (obs !== V_WAIT) begin fails++; $display("FAIL int_to_wait[%0d] obs=%h exp=%h", i, obs, V_WAIT); end
        end
        ack_i = 1'b0;
        tick;
        tests++;
        if (obs !== V_ERR) begin fails++; $display("FAIL int_to_err obs=%h exp=%h", obs, V_ERR); end
        tick;
        tests++;
        if (obs !== V_IDLE) begin fails++; $display("FAIL int_to_idle obs=%h exp=%h", obs, V_IDLE); end
    endtask

    task automatic test_ack_timeout;
        start_xfer(8'hA0, 8'hB0, 8'h02, 1'b0, 8'h00, 8'h00, 8'h00);
        int_i = 1'b1;
        tick;
        tests++;
        if (obs !== V_GO) begin fails++; $display("FAIL ack_to_go obs=%h exp=%h", obs, V_GO); end
        for (int i = 0; i < 13; i++) begin
            tick;
            tests++;
            if (obs !== V_WAIT) begin fails++; $display("FAIL ack_to_wait[%0d] obs=%h exp=%h", i, obs, V_WAIT); end
        end
        int_i = 1'b0;
        tick;
        tests++;
        if (obs !== V_ERR) begin fails++; $display("FAIL ack_to_err obs=%h exp=%h", obs, V_ERR); end
        tick;
        tests++;
        if (obs !== V_IDLE) begin fails++; $display("FAIL ack_to_idle obs=%h exp=%h", obs, V_IDLE); end
    endtask

    // INT on the last WAIT_INT cycle (timer 0) and ACK on the last WAIT_ACK cycle
    task automatic test_ties;
        start_xfer(8'hC1, 8'hD2, 8'h02, 1'b0, 8'h00, 8'h00, 8'h00);
        finish_xfer(4, 13);
    endtask

    task automatic test_back_to_back;
        start_xfer(8'h21, 8'h42, 8'h01, 1'b1, 8'h55, 8'h66, 8'h02);
        ack_i = 1'b1;
        tick;
        tests++;
        if (obs !== V_WAIT) begin fails++; $display("FAIL b2b_early_ack obs=%h exp=%h", obs, V_WAIT); end
        ack_i = 1'b0;
        finish_xfer(0, 1);
        start_xfer(8'h55, 8'h66, 8'h02, 1'b0, 8'h00, 8'h00, 8'h00);
        finish_xfer(0, 3);
    endtask

    task automatic test_reset_mid;
        start_xfer(8'h0F, 8'hF0, 8'h03, 1'b0, 8'h00, 8'h00, 8'h00);
        int_i = 1'b1;
        tick;
        int_i = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        ack_i = 1'b1;
        tick;
        tests++;
        if (obs !== V_IDLE) begin fails++; $display("FAIL rst_mid_values obs=%h exp=%h", obs, V_IDLE); end
        rst = 1'b1;
        ack_i = 1'b0;
        tick;
        tests++;
        if (obs !== V_IDLE) begin fails++; $display("FAIL rst_mid_no_pulse obs=%h exp=%h", obs, V_IDLE); end
        start_xfer(8'h5A, 8'hA5, 8'h01, 1'b0, 8'h00, 8'h00, 8'h00);
        finish_xfer(0, 2);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_zero_len;
        test_int_timeout;
        test_ack_timeout;
        test_ties;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dma_host_sequencer.md
Name: dma_host_sequencer

Overview:
- Processor-side counterpart of the DMA controller FSM. Accepts one transfer request (source address, destination address, byte count) from a CPU-side request port.
- Drives the DMA start/configure/go handshake: inicio, counter load strobes and load.
- Waits for the DMA's INT (counters loaded) and ACK (transfer complete) signals, supervises both with timeouts, and reports completion or error to the requester.

Parameters:
- ADDR_W, 8, width of source/destination addresses and of cfg_data.
- CNT_W, 8, width of byte count; CNT_W <= ADDR_W.
- TIMEOUT, 1023, cycle budget for WAIT_INT, and base budget for WAIT_ACK; must satisfy 1 <= TIMEOUT <= 2^(CNT_W+2)-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_src  in  ADDR_W  source start address.
- req_dst  in  ADDR_W  destination start address.
- req_len  in  CNT_W  byte count.
- inicio  out  1  DMA start strobe.
- cfg_data  out  ADDR_W  value for the counter being loaded; len is zero-extended.
- cfg_wr  out  3  one-hot counter load strobe: bit0 = origin, bit1 = destination, bit2 = byte count.
- load  out  1  DMA go strobe.
- int_i  in  1  DMA INT, meaning all three counters are loaded.
- ack_i  in  1  DMA ACK, meaning the transfer is finished.
- busy  out  1  transfer in progress.
- done_pulse  out  1  one-cycle success indication.
- err_timeout  out  1  one-cycle timeout indication.

Behaviour:
- Moore machine. All outputs are registered or decoded from the state register only; there is no combinational path from any input to any output.
- States and transitions:
  - IDLE: req_ready=1, busy=0. On req_valid, capture src/dst/len.
    - If len==0, go to FIN.
    - Otherwise go to START.
  - START: inicio=1 for exactly one cycle, then go to CFG_SRC.
  - CFG_SRC: cfg_data=src, cfg_wr=001, one cycle, then go to CFG_DST.
  - CFG_DST: cfg_data=dst, cfg_wr=010, one cycle, then go to CFG_LEN.
  - CFG_LEN: cfg_data={0,len}, cfg_wr=100, one cycle, then go to WAIT_INT. Timer loads TIMEOUT.
  - WAIT_INT: hold until int_i=1, then go to GO.
    - If the timer reaches 0 with int_i still low, go to ERR.
    - The timer decrements by 1 per cycle.
  - GO: load=1 for exactly one cycle, then go to WAIT_ACK. Timer loads (len<<2)+TIMEOUT, computed at CNT_W+3 bits with no overflow. The DMA takes 4 cycles per byte.
  - WAIT_ACK: on ack_i=1, go to FIN. On timer expiry (0), go to ERR.
  - FIN: done_pulse=1 for one cycle, then go to IDLE.
  - ERR: err_timeout=1 for one cycle, then go to IDLE. No retry is attempted.
- busy=1 in every state except IDLE. req_ready = (state==IDLE). Requests are never accepted while busy, and are never dropped silently, because req_valid is simply not acknowledged.
- cfg_data=0 and cfg_wr=000 outside the CFG_* states.
- Latency, non-zero len: inicio appears 1 cycle after acceptance. load appears 1 cycle after int_i is sampled high. done_pulse appears 1 cycle after ack_i is sampled high.
- Timeout boundaries:
  - int_i sampled high in the same cycle the timer reaches 0: success wins, go to GO.
  - The same rule applies to ack_i in WAIT_ACK.
- Protocol edge cases:
  - int_i outside WAIT_INT is ignored.
  - ack_i outside WAIT_ACK is ignored, including an early ACK during WAIT_INT.
  - int_i remaining high after GO has no effect.
- Captured request registers are held until the FSM returns to IDLE. Changes on req_* while busy have no effect.
- Reset: when rst=0 at a rising edge, the next state is IDLE. Output values on the following cycle:
  - inicio=0, load=0, cfg_wr=000, cfg_data=0
  - busy=0, req_ready=1
  - done_pulse=0, err_timeout=0
  - timer=0, captured registers=0
- Reset mid-operation, in any state, aborts with no done_pulse and no err_timeout.

Test Plan:
- Basic transfer: req src=0x10, dst=0x80, len=3. Model int_i 2 cycles after cfg_wr=100, and ack_i 12 cycles after load.
  -> inicio, then cfg_wr sequence 001/010/100 with cfg_data 0x10/0x80/0x03 on consecutive cycles.
  -> load 1 cycle after int_i.
  -> done_pulse 1 cycle after ack_i.
  -> busy high throughout, never err_timeout.
- Zero length: req len=0.
  -> no inicio, no cfg_wr, no load.
  -> done_pulse on the 2nd cycle after acceptance, then req_ready=1.
- INT timeout, TIMEOUT=4: int_i never asserted.
  -> err_timeout one cycle after the timer reaches 0 (6 cycles after the CFG_LEN cycle), then IDLE.
  -> no load is ever issued.
- ACK timeout and tie, TIMEOUT=4, len=2 (budget 12):
  -> with no ack_i: err_timeout after budget expiry.
  -> rerun with ack_i exactly on the expiry cycle: done_pulse, no err_timeout.
- Back-pressure and ignored inputs:
  - Hold req_valid high while busy -> req_ready=0 and the second request is accepted only after done_pulse.
  - Early ack_i during WAIT_INT -> ignored.
- Reset mid-WAIT_ACK: drive rst=0 for one cycle.
  -> all outputs reach their reset values the next cycle.
  -> no done_pulse and no err_timeout.
  -> a new request is accepted normally afterwards.
